// File: rtl/mips_pkg.sv
// mips_pkg: shared redirect encodings, fetch FSM states and default vectors for the MIPS fetch front end.
package mips_pkg;
   typedef enum logic [1:0] {REDIR_TGT = 2'd0, REDIR_IRQ = 2'd1, REDIR_EXC = 2'd2, REDIR_RSV = 2'd3} redir_src_e;
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fetch_state_e;
   localparam int          KBIT_DEF      = 31;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch FIFO of {pc, instr} pairs with push/pop/flush and occupancy count.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_instr,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_instr,
   output logic [AW:0]     count
);
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [AW-1:0]   rd, wr;

   assign head_pc    = pc_mem[rd];
   assign head_instr = instr_mem[rd];

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + 1'b1;
         if (pop) rd <= rd + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end

   // storage needs no reset: the head is only observed while count is nonzero
   always_ff @(posedge clk)
      if (push) begin
         pc_mem[wr]    <= push_pc;
         instr_mem[wr] <= push_instr;
      end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner and single-outstanding instruction fetcher feeding decode through a prefetch queue.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter int              KBIT      = KBIT_DEF,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
   parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(IRQ_VEC_DEF),
   parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF)
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pcp4,
   output logic            if_irq,
   input  logic            irq,
   input  logic            redir_valid,
   input  logic [1:0]      redir_src,
   input  logic [XLEN-1:0] redir_target
);
   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [XLEN-1:0] AMASK    = ~((XLEN'(1) << KBIT) | XLEN'(3));

   fetch_state_e    state, state_nx;
   logic [XLEN-1:0] fetch_pc, req_pc, redir_pc, head_pc, head_instr;
   logic [AW:0]     count;
   logic            push, pop;

   assign imem_req  = ~reset & (state == IDLE) & (count != CNT_FULL) & ~redir_valid;
   assign imem_addr = fetch_pc & AMASK;
   // an ack is only a real response while waiting; stale or unsolicited acks are dropped
   assign push      = imem_ack & (state == WAIT) & ~redir_valid;
   assign if_valid  = count != '0;
   assign pop       = if_valid & if_ready & ~redir_valid;
   assign redir_pc  = redir_src == REDIR_IRQ ? IRQ_VEC :
                      redir_src == REDIR_EXC ? EXC_VEC : redir_target & ~XLEN'(3);
   assign if_pc     = if_valid ? head_pc : '0;
   assign if_pcp4   = if_valid ? head_pc + XLEN'(4) : '0;
   assign if_instr  = if_valid ? head_instr : '0;
   assign if_irq    = if_valid & irq & ~head_pc[KBIT];

   always_comb begin
      state_nx = state;
      state_nx = redir_valid                  ? ((state != IDLE && !imem_ack) ? DRAIN : IDLE) :
                 imem_req                     ? WAIT :
                 (imem_ack && state != IDLE)  ? IDLE : state;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_VEC;
         req_pc   <= '0;
      end else begin
         state <= state_nx;
         if (redir_valid) fetch_pc <= redir_pc;
         else if (imem_req) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            req_pc   <= fetch_pc;
         end
      end

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (redir_valid),
      .push_pc    (req_pc),
      .push_instr (imem_rdata),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (count)
   );
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed scenarios against an epoch-tagged stream model of the fetch unit.
module tb_mips_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] AMASK = 32'h7FFF_FFFC;

   logic        clk = 0, reset = 1, imem_ack = 0, if_ready = 0, irq = 0, redir_valid = 0;
   logic        imem_req, if_valid, if_irq;
   logic [31:0] imem_addr, if_instr, if_pc, if_pcp4;
   logic [31:0] imem_rdata = 0, redir_target = 0;
   logic [1:0]  redir_src = 0;

   int n_cmp = 0, n_bad = 0;
   int lat = 1;
   logic spur = 0;

   int held = 0, epoch = 0, out_tag = -1;
   logic [31:0] exp_head = 0, exp_issue = 0;
   logic [31:0] issued[$], popped[$], popped_p4[$];

   mips_fetch_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_pcp4      (if_pcp4),
      .if_irq       (if_irq),
      .irq          (irq),
      .redir_valid  (redir_valid),
      .redir_src    (redir_src),
      .redir_target (redir_target)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] vec(input logic [1:0] s, input logic [31:0] t);
      return s == 2'd1 ? 32'h8000_0004 : s == 2'd2 ? 32'h8000_0008 : {t[31:2], 2'b00};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [1:0] s, input logic [31:0] t);
      redir_src = s;
      redir_target = t;
      redir_valid = 1;
      cyc(1);
      redir_valid = 0;
   endtask

   // memory: fixed latency per request, optional unsolicited ack
   initial begin : mem
      logic req_n;
      logic [31:0] addr_n, maddr;
      int cd;
      cd = 0;
      maddr = 0;
      forever begin
         @(negedge clk);
         req_n = imem_req;
         addr_n = imem_addr;
         @(posedge clk);
         #1;
         imem_ack = 0;
         if (req_n) begin
            maddr = addr_n;
            cd = lat;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               imem_ack = 1;
               imem_rdata = word(maddr);
            end
         end
         if (spur) begin
            imem_ack = 1;
            imem_rdata = 32'hBAD0_BAD0;
            spur = 0;
         end
      end
   end

   // stream model: words of the current epoch that arrived minus words consumed
   initial begin : cmp
      logic ex_req, pop;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rst_valid", 32'(if_valid), 0);
            chk("rst_req", 32'(imem_req), 0);
            chk("rst_irq", 32'(if_irq), 0);
            chk("rst_pc", if_pc, 0);
            chk("rst_pcp4", if_pcp4, 0);
            chk("rst_instr", if_instr, 0);
            held = 0;
            out_tag = -1;
            epoch++;
            exp_head = 0;
            exp_issue = 0;
         end else begin
            ex_req = out_tag < 0 && held < DEPTH && !redir_valid;
            chk("req", 32'(imem_req), 32'(ex_req));
            if (ex_req) chk("addr", imem_addr, exp_issue & AMASK);
            chk("valid", 32'(if_valid), 32'(held > 0));
            if (held > 0) begin
               chk("pc", if_pc, exp_head);
               chk("pcp4", if_pcp4, exp_head + 4);
               chk("instr", if_instr, word(exp_head & AMASK));
               chk("irq", 32'(if_irq), 32'(irq & ~exp_head[31]));
            end else chk("irq_empty", 32'(if_irq), 0);
            pop = held > 0 && if_ready && !redir_valid;
            if (imem_ack) begin
               if (out_tag == epoch && !redir_valid) held++;
               out_tag = -1;
            end
            if (pop) begin
               popped.push_back(if_pc);
               popped_p4.push_back(if_pcp4);
               held--;
               exp_head += 4;
            end
            if (redir_valid) begin
               held = 0;
               epoch++;
               exp_head = vec(redir_src, redir_target);
               exp_issue = exp_head;
            end
            if (ex_req) begin
               issued.push_back(imem_addr);
               out_tag = epoch;
               exp_issue += 4;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin : main
      int k, kp;
      if_ready = 1;
      cyc(2);
      reset = 0;
      // sequential fetch, 1-cycle memory, decode always ready
      cyc(12);
      chk("p1_nissued", 32'(issued.size() >= 3), 1);
      chk("p1_addr0", issued[0], 32'h0);
      chk("p1_addr1", issued[1], 32'h4);
      chk("p1_addr2", issued[2], 32'h8);
      chk("p1_npop", 32'(popped.size() >= 3), 1);
      chk("p1_pc0", popped[0], 32'h0);
      chk("p1_pc1", popped[1], 32'h4);
      chk("p1_pc2", popped[2], 32'h8);
      chk("p1_p40", popped_p4[0], 32'h4);
      chk("p1_p41", popped_p4[1], 32'h8);
      chk("p1_p42", popped_p4[2], 32'hC);
      // decode stalled: queue fills to DEPTH and requests stop
      if_ready = 0;
      redir(0, 32'h200);
      k = issued.size();
      cyc(20);
      chk("p2_full_issues", 32'(issued.size() - k), 4);
      chk("p2_valid", 32'(if_valid), 1);
      chk("p2_head", if_pc, 32'h200);
      if_ready = 1;
      cyc(1);
      if_ready = 0;
      cyc(4);
      chk("p2_one_more", 32'(issued.size() - k), 5);
      chk("p2_head2", if_pc, 32'h204);
      // redirect while a 3-cycle fetch is outstanding
      lat = 3;
      if_ready = 1;
      for (int i = 0; i < 50 && !imem_req; i++) @(negedge clk);
      chk("p3_req_seen", 32'(imem_req), 1);
      @(posedge clk);
      #1;
      redir(0, 32'h40);
      for (int i = 0; i < 50 && !if_valid; i++) cyc(1);
      #1;
      chk("p3_first_pc", if_pc, 32'h40);
      chk("p3_first_instr", if_instr, 32'hFFBF_0040);
      // interrupt tagging in user mode, none in kernel mode
      lat = 1;
      if_ready = 0;
      redir(0, 32'h10);
      for (int i = 0; i < 50 && !if_valid; i++) cyc(1);
      irq = 1;
      #1;
      chk("p4_user_pc", if_pc, 32'h10);
      chk("p4_user_irq", 32'(if_irq), 1);
      redir(1, 32'h0);
      for (int i = 0; i < 50 && !if_valid; i++) cyc(1);
      #1;
      chk("p4_kpc", if_pc, 32'h8000_0004);
      chk("p4_kpcp4", if_pcp4, 32'h8000_0008);
      chk("p4_kinstr", if_instr, 32'hFFFB_0004);
      chk("p4_kirq", 32'(if_irq), 0);
      irq = 0;
      // redirect coinciding with a pop at count 3; unaligned target
      redir(0, 32'h100);
      for (int i = 0; i < 50 && held != 3; i++) cyc(1);
      chk("p5_count3", 32'(held), 3);
      if_ready = 1;
      redir(0, 32'h7);
      if_ready = 0;
      #1;
      chk("p5_flushed", 32'(if_valid), 0);
      for (int i = 0; i < 50 && !if_valid; i++) cyc(1);
      #1;
      chk("p5_pc", if_pc, 32'h4);
      chk("p5_instr", if_instr, 32'hFFFB_0004);
      // address wrap at the top of the address space
      if_ready = 1;
      redir(0, 32'hFFFF_FFFC);
      k = issued.size();
      kp = popped.size();
      cyc(12);
      chk("p6_addr_hi", issued[k], 32'h7FFF_FFFC);
      chk("p6_addr_wrap", issued[k+1], 32'h0);
      chk("p6_pc_hi", popped[kp], 32'hFFFF_FFFC);
      chk("p6_p4_hi", popped_p4[kp], 32'h0);
      chk("p6_pc_wrap", popped[kp+1], 32'h0);
      chk("p6_p4_wrap", popped_p4[kp+1], 32'h4);
      // reset during an outstanding fetch, then an unsolicited ack
      lat = 3;
      for (int i = 0; i < 50 && !imem_req; i++) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1;
      #1;
      chk("p7_req", 32'(imem_req), 0);
      chk("p7_valid", 32'(if_valid), 0);
      chk("p7_addr", imem_addr, 32'h0);
      chk("p7_pc", if_pc, 32'h0);
      chk("p7_instr", if_instr, 32'h0);
      cyc(2);
      reset = 0;
      lat = 1;
      if_ready = 0;
      for (int i = 0; i < 60 && !(held == DEPTH && out_tag < 0); i++) cyc(1);
      chk("p7_full", 32'(held), DEPTH);
      spur = 1;
      cyc(3);
      chk("p7_spur_valid", 32'(if_valid), 1);
      chk("p7_spur_head", if_pc, 32'h0);
      chk("p7_spur_instr", if_instr, 32'hFFFF_0000);
      if_ready = 1;
      cyc(12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
